// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling, optional odd/even parity,
// and a single-entry valid/ready output buffer with framing and overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
   parameter int BITS_N       = 8,
   parameter int PARITY_TYPE  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_in,
   output logic [BITS_N-1:0] data_rx,
   output logic              valid,
   input  logic              ready,
   output logic              parity_err,
   output logic              framing_err,
   output logic              overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (BITS_N > 1) ? $clog2(BITS_N) : 1;

   localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CYC = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CYC_ONE  = CW'(1);
   localparam logic [BW-1:0] LAST_BIT = BW'(BITS_N - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START_BIT,
      S_DATA_BITS,
      S_PARITY_BIT,
      S_STOP_BIT,
      S_WAIT_IDLE
   } state_t;

   state_t            r_state;
   logic              r_sync1;
   logic              r_sync2;
   logic [CW-1:0]     r_cycle_count;
   logic [BW-1:0]     r_bit_n;
   logic [BITS_N-1:0] r_shift;
   logic              r_perr;
   logic              w_bit_end;
   logic              w_par_exp;

   always_comb begin
      w_bit_end = (r_cycle_count == LAST_CYC);
      w_par_exp = (PARITY_TYPE == 1) ? ~^r_shift : ^r_shift;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_state       <= S_IDLE;
         r_cycle_count <= '0;
         r_bit_n       <= '0;
         r_shift       <= '0;
         r_perr        <= 1'b0;
         data_rx       <= '0;
         valid         <= 1'b0;
         parity_err    <= 1'b0;
         framing_err   <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         r_sync1     <= uart_in;
         r_sync2     <= r_sync1;
         framing_err <= 1'b0;
         overrun     <= 1'b0;

         // Consume first; a delivery later in this block overrides it for the simultaneous case.
         if (valid && ready) begin
            valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_cycle_count <= '0;
               if (!r_sync2) begin
                  r_state <= S_START_BIT;
               end
            end

            S_START_BIT: begin
               if (r_cycle_count == HALF_CYC) begin
                  r_cycle_count <= '0;
                  r_bit_n       <= '0;
                  r_perr        <= 1'b0;
                  r_state       <= r_sync2 ? S_IDLE : S_DATA_BITS;
               end else begin
                  r_cycle_count <= r_cycle_count + CYC_ONE;
               end
            end

            S_DATA_BITS: begin
               if (w_bit_end) begin
                  r_cycle_count     <= '0;
                  r_shift[r_bit_n]  <= r_sync2;
                  if (r_bit_n == LAST_BIT) begin
                     r_state <= (PARITY_TYPE != 0) ? S_PARITY_BIT : S_STOP_BIT;
                  end else begin
                     r_bit_n <= r_bit_n + BIT_ONE;
                  end
               end else begin
                  r_cycle_count <= r_cycle_count + CYC_ONE;
               end
            end

            S_PARITY_BIT: begin
               if (w_bit_end) begin
                  r_cycle_count <= '0;
                  r_perr        <= (r_sync2 != w_par_exp);
                  r_state       <= S_STOP_BIT;
               end else begin
                  r_cycle_count <= r_cycle_count + CYC_ONE;
               end
            end

            S_STOP_BIT: begin
               if (w_bit_end) begin
                  r_cycle_count <= '0;
                  if (r_sync2) begin
                     if (!valid || ready) begin
                        data_rx    <= r_shift;
                        parity_err <= r_perr;
                        valid      <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     r_state <= S_IDLE;
                  end else begin
                     framing_err <= 1'b1;
                     r_state     <= S_WAIT_IDLE;
                  end
               end else begin
                  r_cycle_count <= r_cycle_count + CYC_ONE;
               end
            end

            S_WAIT_IDLE: begin
               r_cycle_count <= '0;
               if (r_sync2) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1/8O1/8E1-style UART receiver.
- Samples the asynchronous serial input at mid-bit, reassembles data frames LSB-first, and presents each frame through a valid/ready handshake.
- Sits between the external RX pin and the command-parsing logic of the car controller.
- Pairs with the team's existing UART transmitter and uses identical frame format parameters.

Parameters:
- CLKS_PER_BIT, default 50_000_000/115_200 (=434), clock cycles per UART bit; must be >= 4.
- BITS_N, default 8, data bits per frame (1..16).
- PARITY_TYPE, default 0: 0 = none, 1 = odd, 2 = even.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- uart_in  input  1  serial line from pin; asynchronous, idle high.
- data_rx  output  BITS_N  received data word; stable while valid=1.
- valid  output  1  data_rx holds an unconsumed frame.
- ready  input  1  consumer accepts data_rx when valid && ready on a rising clk.
- parity_err  output  1  parity mismatch flag for the frame in data_rx; qualified by valid.
- framing_err  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  one-cycle pulse when a completed frame is dropped because the buffer is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops = 1; state = IDLE; counters = 0.
  - data_rx = 0; valid = 0; parity_err = 0; framing_err = 0; overrun = 0.
- Input synchronizer: 2 flip-flops, giving rx_s. All sampling uses rx_s only.
- cycle_count counts 0..CLKS_PER_BIT-1 within a bit; bit_n counts 0..BITS_N-1.
- States:
  - IDLE: rx_s==0 -> START_BIT, cycle_count=0.
  - START_BIT: at cycle_count==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - 0: go to DATA_BITS, cycle_count=0, bit_n=0.
    - 1: glitch; return to IDLE, no outputs.
  - DATA_BITS: at cycle_count==CLKS_PER_BIT-1, sample rx_s into shift register bit bit_n (LSB first) and reset cycle_count.
    - When bit_n==BITS_N-1: go to PARITY_BIT if PARITY_TYPE!=0, else STOP_BIT.
    - Otherwise increment bit_n.
  - PARITY_BIT: at cycle_count==CLKS_PER_BIT-1, sample the parity bit; go to STOP_BIT.
    - Expected parity: odd = ~^data, even = ^data.
    - Mismatch sets the internal perr bit.
  - STOP_BIT: at cycle_count==CLKS_PER_BIT-1, sample rx_s.
    - 1: deliver the frame (see buffer rules below); go to IDLE.
    - 0: pulse framing_err for 1 cycle, discard the frame, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then IDLE. Prevents a break or stuck-low line from being read as repeated frames.
- Sampling points therefore sit at mid-bit relative to the detected falling edge.
- Output buffer (single-entry):
  - Delivery when valid==0 or (valid && ready) in the same cycle: data_rx <= shift reg; parity_err <= perr (0 when PARITY_TYPE==0); valid <= 1 on the next edge.
  - Delivery when valid && !ready: data_rx/parity_err unchanged, overrun pulses 1 cycle, new frame dropped.
  - Consume: valid && ready with no simultaneous delivery -> valid <= 0 next edge. data_rx retains its old value.
  - Simultaneous consume + deliver: valid stays 1, data_rx replaced, no overrun.
- Frames with parity errors are still delivered; parity_err accompanies them and must be checked by the consumer.
- Latency: valid rises on the clock edge after the stop-bit sample.
  - Stop-bit sample occurs about (BITS_N + 1 + (PARITY?1:0)) * CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the line falling edge.
  - Add 2 cycles of synchronizer delay to that figure.
- Reset mid-frame: immediate return to the reset state. A partially received frame is lost. Receiver re-syncs on the next falling edge after rst deasserts.
- Back-to-back frames: the IDLE check runs on the cycle after the STOP_BIT transition, so a start bit immediately following the stop bit is detected. No idle gap is required.

Test Plan:
- CLKS_PER_BIT=8, PARITY_TYPE=0, ready=1; send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> valid pulses 1 cycle with data_rx=0xA5, parity_err=0; valid rises within 2+9*8+4 ±1 cycles of the start edge.
- ready=0; send 0x3C then 0x81 back-to-back -> data_rx=0x3C held, valid=1, overrun pulses once at the second stop bit; after ready=1, data_rx=0x3C consumed and valid falls.
- PARITY_TYPE=2; send 0x07 with parity bit 0 (wrong) -> data_rx=0x07, valid=1, parity_err=1; resend with parity 1 -> parity_err=0.
- Send 0x55 with stop bit 0, then hold line low 40 cycles, then high -> framing_err pulses once, valid stays 0, no further frames until the line returns high; the next frame 0x12 is received correctly.
- Low glitch of 2 cycles on an idle line -> rejected at the start-bit check; no valid, no errors, state returns to IDLE.
- Assert rst low during bit 4 of a frame, release, then send 0xF0 -> all outputs 0 during reset; only 0xF0 is delivered.
